// File: rtl/scratchpad_tile_sequencer.sv
// Tile sequencer in front of the scratchpad port of the memory arbiter.
// A tile command (base, rows, direction) becomes a row-major series of
// single-word arbiter requests; loaded words stream to the row writer and
// store words are pulled from the row reader.
//
// Handshakes: a ld_valid/ld_ready or st_valid/st_ready transfer happens on
// a rising edge where both are high; the valid side holds its payload
// stable until that edge. sLoad/sStore are held with a stable address/data
// until the matching hit, and drop on the cycle after the hit.
module scratchpad_tile_sequencer #(
  parameter int WORD_W        = 32,
  parameter int ADDR_W        = 32,
  parameter int WORDS_PER_ROW = 4,
  parameter int MAX_ROWS      = 4,
  parameter int ROW_STRIDE    = 64,
  localparam int ROWS_W       = $clog2(MAX_ROWS + 1),
  localparam int ROW_IDX_W    = $clog2(MAX_ROWS),
  localparam int COL_W        = $clog2(WORDS_PER_ROW)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_store,
  input  logic [ADDR_W-1:0]    cmd_base,
  input  logic [ROWS_W-1:0]    cmd_rows,
  output logic                 done,
  output logic                 err,
  output logic                 sLoad,
  output logic                 sStore,
  output logic [ADDR_W-1:0]    load_addr,
  output logic [ADDR_W-1:0]    store_addr,
  output logic [WORD_W-1:0]    store_data,
  input  logic                 sLoad_hit,
  input  logic                 sStore_hit,
  input  logic [WORD_W-1:0]    load_data,
  output logic                 ld_valid,
  input  logic                 ld_ready,
  output logic [WORD_W-1:0]    ld_data,
  output logic [ROW_IDX_W-1:0] ld_row,
  output logic [COL_W-1:0]     ld_col,
  input  logic                 st_valid,
  output logic                 st_ready,
  input  logic [WORD_W-1:0]    st_data,
  output logic [2:0]           dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LD_REQ   = 3'd1,
    S_LD_OUT   = 3'd2,
    S_ST_FETCH = 3'd3,
    S_ST_REQ   = 3'd4,
    S_FIN      = 3'd5
  } state_e;

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [ADDR_W-1:0]    row_base_q, row_base_d;
  logic [ROWS_W-1:0]    row_q, row_d;
  logic [COL_W-1:0]     col_q, col_d;
  logic [ROWS_W-1:0]    rows_q, rows_d;
  logic                 err_q, err_d;
  logic [WORD_W-1:0]    st_word_q, st_word_d;
  logic [WORD_W-1:0]    ld_data_q, ld_data_d;
  logic [ROW_IDX_W-1:0] ld_row_q, ld_row_d;
  logic [COL_W-1:0]     ld_col_q, ld_col_d;

  logic cmd_bad;
  logic last_col;
  logic last_word;
  logic do_adv;

  // Command legality and position within the tile
  assign cmd_bad   = (cmd_rows == '0) || (cmd_rows > ROWS_W'(MAX_ROWS));
  assign last_col  = (col_q == COL_W'(WORDS_PER_ROW - 1));
  assign last_word = last_col && (row_q == rows_q - ROWS_W'(1));
  assign do_adv    = ((state_q == S_LD_OUT) && ld_ready) ||
                     ((state_q == S_ST_REQ) && sStore_hit);

  // State register and datapath registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      row_base_q <= '0;
      row_q      <= '0;
      col_q      <= '0;
      rows_q     <= '0;
      err_q      <= 1'b0;
      st_word_q  <= '0;
      ld_data_q  <= '0;
      ld_row_q   <= '0;
      ld_col_q   <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      row_base_q <= row_base_d;
      row_q      <= row_d;
      col_q      <= col_d;
      rows_q     <= rows_d;
      err_q      <= err_d;
      st_word_q  <= st_word_d;
      ld_data_q  <= ld_data_d;
      ld_row_q   <= ld_row_d;
      ld_col_q   <= ld_col_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          if (cmd_bad)        state_d = S_FIN;
          else if (cmd_store) state_d = S_ST_FETCH;
          else                state_d = S_LD_REQ;
        end
      end
      S_LD_REQ:   if (sLoad_hit)  state_d = S_LD_OUT;
      S_LD_OUT:   if (ld_ready)   state_d = last_word ? S_FIN : S_LD_REQ;
      S_ST_FETCH: if (st_valid)   state_d = S_ST_REQ;
      S_ST_REQ:   if (sStore_hit) state_d = last_word ? S_FIN : S_ST_FETCH;
      S_FIN:      state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Datapath next values: command latch, word capture and address walk
  always_comb begin
    addr_d     = addr_q;
    row_base_d = row_base_q;
    row_d      = row_q;
    col_d      = col_q;
    rows_d     = rows_q;
    err_d      = err_q;
    st_word_d  = st_word_q;
    ld_data_d  = ld_data_q;
    ld_row_d   = ld_row_q;
    ld_col_d   = ld_col_q;
    case (state_q)
      S_IDLE: begin
        err_d = 1'b0;
        if (cmd_valid) begin
          if (cmd_bad) begin
            err_d = 1'b1;
          end else begin
            addr_d     = cmd_base;
            row_base_d = cmd_base;
            rows_d     = cmd_rows;
            row_d      = '0;
            col_d      = '0;
          end
        end
      end
      S_LD_REQ: begin
        if (sLoad_hit) begin
          ld_data_d = load_data;
          ld_row_d  = row_q[ROW_IDX_W-1:0];
          ld_col_d  = col_q;
        end
      end
      S_ST_FETCH: if (st_valid) st_word_d = st_data;
      S_FIN:      err_d = 1'b0;
      default: ;
    endcase
    // Address arithmetic wraps silently at 2^ADDR_W
    if (do_adv) begin
      if (last_col) begin
        col_d      = '0;
        row_d      = row_q + ROWS_W'(1);
        row_base_d = row_base_q + ADDR_W'(ROW_STRIDE);
        addr_d     = row_base_q + ADDR_W'(ROW_STRIDE);
      end else begin
        col_d  = col_q + COL_W'(1);
        addr_d = addr_q + ADDR_W'(WORD_W / 8);
      end
    end
  end

  // Output decode; cmd_ready stays low while reset is asserted
  always_comb begin
    cmd_ready   = (state_q == S_IDLE) && !RST;
    sLoad       = (state_q == S_LD_REQ);
    sStore      = (state_q == S_ST_REQ);
    load_addr   = addr_q;
    store_addr  = addr_q;
    store_data  = st_word_q;
    ld_valid    = (state_q == S_LD_OUT);
    ld_data     = ld_data_q;
    ld_row      = ld_row_q;
    ld_col      = ld_col_q;
    st_ready    = (state_q == S_ST_FETCH);
    done        = (state_q == S_FIN);
    err         = (state_q == S_FIN) && err_q;
    dbg_state_o = state_q;
  end

endmodule

// File: tb/tb_scratchpad_tile_sequencer.sv
// Bench for scratchpad_tile_sequencer: arbiter/RAM model, row reader and
// row writer models, scoreboard queues filled from a tile-level model.
module tb_scratchpad_tile_sequencer;

  localparam int WPR        = 4;
  localparam int MAX_ROWS   = 4;
  localparam int ROW_STRIDE = 64;

  // ---------------- clock / reset ----------------
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  always #5 CLK = ~CLK;

  logic        cmd_valid = 0, cmd_store = 0;
  logic [31:0] cmd_base = 0;
  logic [2:0]  cmd_rows = 0;
  logic        cmd_ready, done, err, sLoad, sStore;
  logic [31:0] load_addr, store_addr, store_data;
  logic        sLoad_hit = 0, sStore_hit = 0;
  logic [31:0] load_data = 0;
  logic        ld_valid, ld_ready = 0;
  logic [31:0] ld_data;
  logic [1:0]  ld_row, ld_col;
  logic        st_valid = 0, st_ready;
  logic [31:0] st_data = 0;
  logic [2:0]  dbg_state;

  scratchpad_tile_sequencer dut (
    .CLK(CLK), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_store(cmd_store),
    .cmd_base(cmd_base), .cmd_rows(cmd_rows), .done(done), .err(err),
    .sLoad(sLoad), .sStore(sStore), .load_addr(load_addr),
    .store_addr(store_addr), .store_data(store_data),
    .sLoad_hit(sLoad_hit), .sStore_hit(sStore_hit), .load_data(load_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
    .ld_row(ld_row), .ld_col(ld_col),
    .st_valid(st_valid), .st_ready(st_ready), .st_data(st_data),
    .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_la_q[$];    // expected load request addresses
  logic [35:0] exp_ld_q[$];    // {row, col, data} expected at the row writer
  logic [63:0] exp_st_q[$];    // {addr, data} expected at store hits
  logic [16:0] exp_done_q[$];  // {words, err} per command
  logic [31:0] st_src_q[$];    // words the row reader will offer
  logic [31:0] ram [logic [31:0]];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: event seen with nothing expected", name);
  endtask

  function automatic logic [31:0] ram_rd(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    return a ^ 32'h5A5A_1234;
  endfunction

  // ---------------- environment controls ----------------
  int arb_delay_max = 0;
  int arb_wait      = 0;
  bit arb_block     = 0;
  bit stray_en      = 0;
  int ld_ready_pct  = 100;
  int ld_hold       = 0;
  int stall_word    = -1;
  int stall_len     = 0;
  bit stall_used    = 0;
  int st_gap_fixed  = -1;
  int st_gap        = 0;
  bit st_fire_s     = 0;
  int cmd_hits      = 0;
  int ld_words_cmd  = 0;

  // ---------------- driver: arbiter/RAM, row reader, row writer ----------------
  initial forever begin
    @(posedge CLK);
    #1;
    sLoad_hit  = 0;
    sStore_hit = 0;
    if (RST) begin
      st_valid = 0;
      ld_ready = 0;
    end else begin
      if (sLoad) begin
        if (arb_wait > 0) arb_wait--;
        else begin
          sLoad_hit = 1;
          load_data = ram_rd(load_addr);
          arb_wait  = $urandom_range(0, arb_delay_max);
        end
      end else if (sStore) begin
        if (arb_block) ;
        else if (arb_wait > 0) arb_wait--;
        else begin
          sStore_hit      = 1;
          ram[store_addr] = store_data;
          arb_wait        = $urandom_range(0, arb_delay_max);
        end
      end else if (stray_en && $urandom_range(0, 4) == 0) begin
        if ($urandom_range(0, 1) == 1) sLoad_hit = 1;
        else sStore_hit = 1;
        load_data = $urandom;
      end

      if (st_fire_s && st_src_q.size() > 0) begin
        void'(st_src_q.pop_front());
        st_gap = (st_gap_fixed >= 0) ? st_gap_fixed : $urandom_range(0, 2);
      end
      if (st_gap > 0) begin
        st_valid = 0;
        st_gap--;
      end else if (st_src_q.size() > 0) begin
        st_valid = 1;
        st_data  = st_src_q[0];
      end else begin
        st_valid = 0;
        st_data  = $urandom;
      end

      if (ld_hold > 0) begin
        ld_ready = 0;
        ld_hold--;
      end else if (ld_valid && !stall_used && ld_words_cmd == stall_word) begin
        stall_used = 1;
        ld_hold    = stall_len - 1;
        ld_ready   = 0;
      end else begin
        ld_ready = ($urandom_range(1, 100) <= ld_ready_pct);
      end
    end
  end

  // ---------------- monitor ----------------
  logic        p_sload = 0, p_sstore = 0, p_ld_hit = 0, p_st_hit = 0;
  logic        p_ld_valid = 0, p_ld_fire = 0;
  logic [31:0] p_load_addr = 0;
  logic [63:0] p_st = 0;
  logic [35:0] p_ld = 0;

  initial forever begin
    logic [16:0] e;
    @(negedge CLK);
    if (RST) begin
      cmd_hits     = 0;
      ld_words_cmd = 0;
    end else begin
      if (sLoad || sStore) check("req_exclusive", sLoad & sStore, 0);
      if (p_ld_hit) check("sload_drops_after_hit", sLoad, 0);
      if (p_st_hit) check("sstore_drops_after_hit", sStore, 0);
      if (sLoad && p_sload && !p_ld_hit) check("load_addr_hold", load_addr, p_load_addr);
      if (sStore && p_sstore && !p_st_hit) check("store_req_hold", {store_addr, store_data}, p_st);
      if (ld_valid && p_ld_valid && !p_ld_fire) check("ld_word_hold", {ld_row, ld_col, ld_data}, p_ld);
      if (ld_valid) check("no_sload_while_ld_valid", sLoad, 0);
      if (sLoad && sLoad_hit) begin
        cmd_hits++;
        if (exp_la_q.size() > 0) check("load_addr", load_addr, exp_la_q.pop_front());
        else unexpected("load_request");
      end
      if (sStore && sStore_hit) begin
        cmd_hits++;
        if (exp_st_q.size() > 0) check("store_addr_data", {store_addr, store_data}, exp_st_q.pop_front());
        else unexpected("store_request");
      end
      if (ld_valid && ld_ready) begin
        ld_words_cmd++;
        if (exp_ld_q.size() > 0) check("ld_row_col_data", {ld_row, ld_col, ld_data}, exp_ld_q.pop_front());
        else unexpected("ld_word");
      end
      if (done) begin
        if (exp_done_q.size() > 0) begin
          e = exp_done_q.pop_front();
          check("done_err", err, e[0]);
          check("words_transferred", cmd_hits, e[16:1]);
        end else unexpected("done");
        cmd_hits     = 0;
        ld_words_cmd = 0;
      end
    end
    p_sload     = sLoad;
    p_sstore    = sStore;
    p_ld_hit    = sLoad && sLoad_hit && !RST;
    p_st_hit    = sStore && sStore_hit && !RST;
    p_ld_valid  = ld_valid;
    p_ld_fire   = ld_valid && ld_ready && !RST;
    p_load_addr = load_addr;
    p_st        = {store_addr, store_data};
    p_ld        = {ld_row, ld_col, ld_data};
    st_fire_s   = st_valid && st_ready && !RST;
  end

  // ---------------- reference model and command tasks ----------------
  task automatic expect_cmd(input bit store, input logic [31:0] base, input int rows);
    bit legal;
    logic [31:0] a, w;
    legal = (rows >= 1) && (rows <= MAX_ROWS);
    if (legal) begin
      for (int r = 0; r < rows; r++) begin
        for (int c = 0; c < WPR; c++) begin
          a = base + 32'(r * ROW_STRIDE) + 32'(c * 4);
          if (store) begin
            w = $urandom;
            st_src_q.push_back(w);
            exp_st_q.push_back({a, w});
          end else begin
            exp_la_q.push_back(a);
            exp_ld_q.push_back({2'(r), 2'(c), ram_rd(a)});
          end
        end
      end
    end
    exp_done_q.push_back({16'(legal ? rows * WPR : 0), !legal});
    stall_used = 0;
    st_gap     = (st_gap_fixed >= 0) ? st_gap_fixed : 0;
  endtask

  task automatic send_cmd(input bit store, input logic [31:0] base, input int rows);
    int t;
    t = 0;
    while (!cmd_ready && t < 100) begin
      @(negedge CLK);
      #1;
      t++;
    end
    if (!cmd_ready) unexpected("cmd_ready_timeout");
    cmd_valid = 1;
    cmd_store = store;
    cmd_base  = base;
    cmd_rows  = 3'(rows);
    @(negedge CLK);
    #1;
    cmd_valid = 0;
    cmd_store = 1'($urandom);
    cmd_base  = $urandom;
    cmd_rows  = 3'($urandom);
  endtask

  task automatic flush_all();
    exp_la_q.delete();
    exp_ld_q.delete();
    exp_st_q.delete();
    exp_done_q.delete();
    st_src_q.delete();
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (exp_done_q.size() != 0 && t < 3000) begin
      @(negedge CLK);
      #1;
      t++;
    end
    if (exp_done_q.size() != 0) begin
      $display("FAIL done_timeout: %0d commands still pending", exp_done_q.size());
      n_checks++;
      n_errors++;
      flush_all();
    end else begin
      check("leftover_expectations", exp_la_q.size() + exp_ld_q.size() + exp_st_q.size(), 0);
    end
  endtask

  task automatic issue_cmd(input bit store, input logic [31:0] base, input int rows);
    expect_cmd(store, base, rows);
    send_cmd(store, base, rows);
    wait_done();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, {cmd_ready, done, err, sLoad, sStore, ld_valid, st_ready,
                            ld_row, ld_col, dbg_state}, 0);
    check({tag, "_addr"}, {load_addr, store_addr}, 0);
    check({tag, "_data"}, {store_data, ld_data}, 0);
  endtask

  task automatic wait_cond_hits(input int n);
    int t;
    t = 0;
    while (cmd_hits < n && t < 500) begin
      @(negedge CLK);
      #1;
      t++;
    end
    check("abort_setup_hits", cmd_hits, n);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] base, last_st_base;
    int rows;
    bit store;
    int t;
    last_st_base = 32'h0;

    repeat (2) @(negedge CLK);
    #1;
    check_all_zero("reset");
    RST = 0;
    @(negedge CLK);
    #1;

    // load, two rows, immediate arbiter, writer always ready
    issue_cmd(0, 32'h0000_0100, 2);
    // store with row reader gaps, then read the stored words back
    st_gap_fixed = 3;
    issue_cmd(1, 32'h0000_0200, 1);
    st_gap_fixed = -1;
    issue_cmd(0, 32'h0000_0200, 1);
    // writer stalls on the second word
    stall_word = 1;
    stall_len  = 5;
    issue_cmd(0, 32'h0000_0400, 1);
    stall_word = -1;
    // illegal row counts
    issue_cmd(0, 32'h0000_0500, 0);
    issue_cmd(1, 32'h0000_0500, MAX_ROWS + 1);
    // address wrap
    issue_cmd(0, 32'hFFFF_FFF8, 1);
    issue_cmd(1, 32'hFFFF_FFC0, 2);

    // reset while the third store word is being requested
    expect_cmd(1, 32'h0000_0300, 1);
    send_cmd(1, 32'h0000_0300, 1);
    wait_cond_hits(2);
    arb_block = 1;
    t = 0;
    while (!sStore && t < 100) begin
      @(negedge CLK);
      #1;
      t++;
    end
    check("abort_in_st_req", sStore, 1);
    RST = 1;
    @(negedge CLK);
    #1;
    check_all_zero("abort");
    flush_all();
    arb_block = 0;
    RST = 0;
    @(negedge CLK);
    #1;
    issue_cmd(0, 32'h0000_0300, 1);

    // randomized commands
    arb_delay_max = 3;
    ld_ready_pct  = 60;
    stray_en      = 1;
    for (int i = 0; i < 24; i++) begin
      store = 1'($urandom_range(0, 1));
      base  = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) base = 32'hFFFF_FF00 | ($urandom & 32'hFC);
      if (!store && $urandom_range(0, 1) == 1) base = last_st_base;
      if ($urandom_range(0, 9) < 8) rows = $urandom_range(1, MAX_ROWS);
      else rows = ($urandom_range(0, 1) == 1) ? 0 : MAX_ROWS + 1;
      if (store) last_st_base = base;
      issue_cmd(store, base, rows);
    end

    repeat (3) @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // ---------------- global time limit ----------------
  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
